// File: rtl/demux_tdm_1_16.sv
// Time-division 1:16 demultiplexer with a double-buffered parallel output.
// Channels 0..14 collect in a shadow buffer. Channel 15 goes straight from din
// into q together with the shadow, so a frame publishes on the edge that
// accepts its last beat.
module demux_tdm_1_16 #(
  parameter int DATA_W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    din,
  input  logic                 din_valid,
  input  logic                 frame_start,
  output logic [16*DATA_W-1:0] q,
  output logic                 q_valid,
  output logic                 frame_done,
  output logic                 sync_err,
  output logic [3:0]           ch,
  output logic                 busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              ch_nxt;
  logic                    shadow_we;
  logic [3:0]              wr_idx;
  logic                    publish;
  logic                    resync;
  logic [14:0][DATA_W-1:0] shadow;
  logic [16*DATA_W-1:0]    q_cat;

  // A frame_start beat always restarts at slot 0; otherwise write at ch.
  assign wr_idx = frame_start ? 4'd0 : ch;
  assign busy   = (state == RUN);

  // Next-state, channel advance and publish/resync decode.
  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    shadow_we = 1'b0;
    publish   = 1'b0;
    resync    = 1'b0;
    if (din_valid) begin
      unique case (state)
        IDLE: begin
          // Beats without frame_start are dropped silently while idle.
          if (frame_start) begin
            shadow_we = 1'b1;
            ch_nxt    = 4'd1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (frame_start) begin
            // frame_start wins over completion, even at ch==15.
            resync    = 1'b1;
            shadow_we = 1'b1;
            ch_nxt    = 4'd1;
          end else if (ch == 4'd15) begin
            publish   = 1'b1;
            ch_nxt    = 4'd0;
            state_nxt = IDLE;
          end else begin
            shadow_we = 1'b1;
            ch_nxt    = ch + 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Flattened {din, shadow[14..0]} presented to q on completion.
  always_comb begin
    q_cat = '0;
    for (int k = 0; k < 15; k++) q_cat[k*DATA_W +: DATA_W] = shadow[k];
    q_cat[15*DATA_W +: DATA_W] = din;
  end

  // FSM state and channel counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ch    <= 4'd0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
    end
  end

  // Shadow buffer: one slot written per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (shadow_we) begin
      for (int k = 0; k < 15; k++)
        if (wr_idx == 4'(k)) shadow[k] <= din;
    end
  end

  // Output buffer and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      q_valid    <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= publish;
      sync_err   <= resync;
      if (publish) begin
        q       <= q_cat;
        q_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/demux_tdm_1_16.md
Name: demux_tdm_1_16

Overview:
- Time-division 1:16 demultiplexer; the receive-side counterpart of the 16:1 selection mux used in the datapath.
- Accepts a serial stream of 16 channel samples per frame, tagged by a frame-start marker, and steers each sample to its own channel slot.
- Double-buffered: the parallel output updates atomically only when a complete, in-sync frame has been collected.
- Sits after any 16:1 TDM serializer; feeds parallel consumers such as LEDs, registers or compare logic.

Parameters:
DATA_W, 1, width of one channel sample in bits (1..8).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
din  input  DATA_W  serial channel sample.
din_valid  input  1  din carries a sample this cycle.
frame_start  input  1  qualified by din_valid: the current sample is channel 0 of a new frame.
q  output  16*DATA_W  parallel output; slice [k*DATA_W +: DATA_W] = channel k of the last complete frame.
q_valid  output  1  at least one complete frame has been published since reset.
frame_done  output  1  one-cycle pulse in the cycle q updates.
sync_err  output  1  one-cycle pulse when a frame is aborted by an early frame_start.
ch  output  4  index of the next channel expected (0..15).
busy  output  1  high while in RUN.

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces q=0, shadow=0, ch=0, q_valid=0, frame_done=0, sync_err=0, busy=0, state=IDLE. Release takes effect on the next clk edge.
- Internal state: 15-slot shadow buffer (channels 0..14), 4-bit ch counter, FSM with states IDLE and RUN.
- A beat is accepted only when din_valid=1. When din_valid=0, nothing changes: ch holds, and there is no timeout.
- IDLE:
  - valid beat with frame_start=1: shadow[0]<=din, ch<=1, go to RUN.
  - valid beat with frame_start=0: discarded; ch stays 0, no error flagged.
- RUN, valid beat with frame_start=0 and ch<15: shadow[ch]<=din, ch<=ch+1.
- RUN, valid beat with frame_start=0 and ch==15:
  - q<={din, shadow[14..0]}, so channel 15 comes directly from din.
  - frame_done=1 for exactly that cycle; q_valid<=1 (sticky until reset).
  - ch<=0, go to IDLE.
- RUN, valid beat with frame_start=1, at any ch including 15:
  - resynchronisation: sync_err=1 for one cycle; q is untouched.
  - shadow[0]<=din, ch<=1, stay in RUN.
  - Frame_start takes priority over completion.
- Latency: q reflects a frame on the clock edge that accepts its channel-15 beat. frame_done is registered and asserts in the cycle after that edge, aligned with the new q.
- Back-to-back frames are allowed: the frame_start beat may arrive in the cycle right after channel 15. Sustained throughput is one sample per clock.
- q changes only on frame completion or reset, never mid-frame. Partial frames are never visible.
- frame_done and sync_err are never asserted together.
- ch wraps 15->0 only via completion; it never exceeds 15.
- busy = (state==RUN).
- Reset asserted mid-frame discards the partial frame and clears q.

Test Plan:
1. Reset, then 16 consecutive valid beats with din = channel index LSB (DATA_W=1: 0,1,0,1,...) and frame_start on beat 0 -> q=16'hAAAA one cycle after beat 15. frame_done high exactly 1 cycle, q_valid=1, ch=0.
2. Same frame with din_valid dropped for 3 cycles after beats 4 and 10 -> identical q=16'hAAAA. ch holds at 5 and 11 during the gaps. No frame_done until beat 15.
3. Frame 1 all ones (q=16'hFFFF), then a second frame started, with frame_start reasserted at ch=9 and a full zero frame following -> sync_err pulses once at the abort. q stays 16'hFFFF until the new frame completes, then becomes 16'h0000. One frame_done per completed frame.
4. Valid beats with frame_start=0 while in IDLE (5 beats of 1) -> q, ch, q_valid unchanged; no pulses.
5. Two back-to-back frames with no gap (16'h1234 then 16'hBEEF, LSB channel first) -> frame_done pulses 16 cycles apart. q shows 16'h1234, then 16'hBEEF.
6. Assert rst_n=0 asynchronously at ch=7 of a frame, after a previous q=16'h5A5A -> q=0, q_valid=0, ch=0, busy=0 immediately, without a clock edge. The next full frame publishes correctly.
